door_request_ctrl: RTL and testbench

- Owns the elevator's request register and door sequencing; sits between the raw call buttons and the motion algorithm FSM.
- Latches button presses into the 10-bit request vector consumed by the algorithm.
- Detects stops and runs the door open/close timing, driving the algorithm's wait input.
- Clears the requests served at each stop.

---
 rtl/door_request_ctrl.sv | 145 ++++++++++++++
 tb/tb_door_request_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/door_request_ctrl.sv
// Elevator request register and door sequencer: latches call buttons, detects stops,
// times the door open/close cycle and holds the motion algorithm while the door is busy.
module door_request_ctrl #(
    parameter int unsigned T_ABIERTA = 8,
    parameter int unsigned T_CIERRE  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] botones,
    input  logic [3:0] estado,
    input  logic       obstaculo,
    output logic [9:0] s,
    output logic       esperar,
    output logic       puerta_abierta
);

    localparam int unsigned T_MAX = (T_ABIERTA > T_CIERRE) ? T_ABIERTA : T_CIERRE;
    localparam int unsigned CW    = ($clog2(T_MAX) < 1) ? 1 : $clog2(T_MAX);
    localparam logic [CW-1:0] LD_ABIERTA = CW'(T_ABIERTA - 1);
    localparam logic [CW-1:0] LD_CIERRE  = CW'(T_CIERRE - 1);

    typedef enum logic [1:0] {
        CERRADA,
        ABIERTA,
        CERRANDO
    } door_state_t;

    // Requests served when the cabin stops at a floor heading in a given direction.
    function automatic logic [9:0] served_mask(input logic [1:0] floor, input logic up);
        logic [9:0] m;
        m = '0;
        case (floor)
            2'd0:    m = 10'h041;
            2'd1:    m = up ? 10'h084 : 10'h082;
            2'd2:    m = up ? 10'h110 : 10'h108;
            default: m = 10'h220;
        endcase
        return m;
    endfunction

    function automatic logic [9:0] opposite_mask(input logic [1:0] floor, input logic up);
        logic [9:0] m;
        m = '0;
        case (floor)
            2'd1:    m = up ? 10'h002 : 10'h004;
            2'd2:    m = up ? 10'h008 : 10'h010;
            default: m = '0;
        endcase
        return m;
    endfunction

    door_state_t   r_state;
    door_state_t   w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_mov_prev;
    logic [9:0]    r_s;
    logic          r_puerta;

    logic          w_moving;
    logic          w_parada;
    logic [9:0]    w_mask;
    logic [9:0]    w_opp;
    logic          w_llamada;
    logic          w_busy;
    logic          w_clr_en;
    logic [9:0]    w_clr;

    assign w_moving = estado[3];
    assign w_parada = r_mov_prev & ~w_moving;
    assign w_mask   = served_mask(estado[1:0], estado[2]);
    assign w_opp    = opposite_mask(estado[1:0], estado[2]);
    assign w_busy   = (r_state != CERRADA);

    // Opposite-direction hall calls only open the door on a fresh press; a pending one
    // is left for the algorithm so it cannot hold the door open indefinitely.
    assign w_llamada = ~w_moving & ((|((botones | r_s) & w_mask)) | (|(botones & w_opp)));

    // Clearing covers the opening cycle too, so a press that opens the door is absorbed.
    assign w_clr_en = w_parada | (~w_moving & (w_busy | w_llamada));
    assign w_clr    = w_clr_en ? w_mask : '0;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            CERRADA: begin
                if (w_parada | w_llamada) begin
                    w_next     = ABIERTA;
                    w_cnt_next = LD_ABIERTA;
                end
            end
            ABIERTA: begin
                if (obstaculo | w_llamada) begin
                    w_cnt_next = LD_ABIERTA;
                end else if (r_cnt == '0) begin
                    w_next     = CERRANDO;
                    w_cnt_next = LD_CIERRE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            CERRANDO: begin
                if (obstaculo | w_llamada) begin
                    w_next     = ABIERTA;
                    w_cnt_next = LD_ABIERTA;
                end else if (r_cnt == '0) begin
                    w_next     = CERRADA;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: begin
                w_next     = CERRADA;
                w_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= CERRADA;
            r_cnt      <= '0;
            r_mov_prev <= 1'b0;
            r_s        <= '0;
            r_puerta   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_mov_prev <= w_moving;
            r_s        <= (r_s | botones) & ~w_clr;
            r_puerta   <= (w_next != CERRADA);
        end
    end

    assign s              = r_s;
    assign puerta_abierta = r_puerta;
    assign esperar        = w_busy | w_parada | (~w_busy & w_llamada);

    a_no_motion_with_door_open: assert property (
        @(posedge clk) disable iff (reset)
        !(w_moving && !r_mov_prev && (r_state != CERRADA))
    );

endmodule

// File: tb/tb_door_request_ctrl.sv
// Self-checking bench for door_request_ctrl: vector table, directed door sequences,
// and randomized traffic against a remaining-open-time reference model.
module tb_door_request_ctrl;

    localparam int TA = 8;
    localparam int TC = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] botones = '0;
    logic [3:0] estado = '0;
    logic       obstaculo = 1'b0;
    logic [9:0] s;
    logic       esperar;
    logic       puerta_abierta;

    int n_checks = 0;
    int n_err = 0;

    logic [9:0] m_s;
    int         m_remain;
    logic       m_mov_prev;

    door_request_ctrl #(.T_ABIERTA(TA), .T_CIERRE(TC)) dut (
        .clk            (clk),
        .reset          (reset),
        .botones        (botones),
        .estado         (estado),
        .obstaculo      (obstaculo),
        .s              (s),
        .esperar        (esperar),
        .puerta_abierta (puerta_abierta)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (actual=running required=finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] m_served(input int f, input bit up);
        logic [9:0] r;
        r = '0;
        r[6 + f] = 1'b1;
        if (f == 0) r[0] = 1'b1;
        else if (f == 3) r[5] = 1'b1;
        else r[up ? 2 * f : 2 * f - 1] = 1'b1;
        return r;
    endfunction

    function automatic logic [9:0] m_opp(input int f, input bit up);
        logic [9:0] r;
        r = '0;
        if (f == 1 || f == 2) r[up ? 2 * f - 1 : 2 * f] = 1'b1;
        return r;
    endfunction

    // Returns at posedge+1 with reset released and one quiet edge applied.
    task automatic apply_reset(input logic [3:0] e);
        @(negedge clk);
        #2;
        reset = 1'b1;
        estado = e;
        botones = '0;
        obstaculo = 1'b0;
        #1;
        check("reset_s", s, 10'h000);
        check("reset_puerta", {9'b0, puerta_abierta}, 10'h000);
        check("reset_esperar", {9'b0, esperar}, 10'h000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic count_open(input int obst_at, input int press_at, output int n);
        int guard;
        n = 0;
        guard = 0;
        while (puerta_abierta === 1'b1 && guard < 100) begin
            n++;
            guard++;
            obstaculo = (n == obst_at);
            botones = (n == press_at) ? 10'h200 : 10'h000;
            @(posedge clk);
            #1;
        end
        obstaculo = 1'b0;
        botones = '0;
    endtask

    typedef struct {
        logic [3:0] est;
        logic [9:0] btn;
        logic       exp_esp;
        logic [9:0] exp_s;
        logic       exp_p;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n;
        logic mov, up, par, llam, open, esp, clr_on, trig;
        int f;
        logic [9:0] mask, opp;

        tbl[0]  = '{4'b0100, 10'h040, 1'b1, 10'h000, 1'b1};
        tbl[1]  = '{4'b0100, 10'h001, 1'b1, 10'h000, 1'b1};
        tbl[2]  = '{4'b0100, 10'h002, 1'b0, 10'h002, 1'b0};
        tbl[3]  = '{4'b0101, 10'h004, 1'b1, 10'h000, 1'b1};
        tbl[4]  = '{4'b0101, 10'h002, 1'b1, 10'h002, 1'b1};
        tbl[5]  = '{4'b0001, 10'h002, 1'b1, 10'h000, 1'b1};
        tbl[6]  = '{4'b0101, 10'h080, 1'b1, 10'h000, 1'b1};
        tbl[7]  = '{4'b0110, 10'h010, 1'b1, 10'h000, 1'b1};
        tbl[8]  = '{4'b0010, 10'h010, 1'b1, 10'h010, 1'b1};
        tbl[9]  = '{4'b0011, 10'h020, 1'b1, 10'h000, 1'b1};
        tbl[10] = '{4'b0111, 10'h200, 1'b1, 10'h000, 1'b1};
        tbl[11] = '{4'b0111, 10'h100, 1'b0, 10'h100, 1'b0};
        tbl[12] = '{4'b1101, 10'h080, 1'b0, 10'h080, 1'b0};

        for (int i = 0; i < 13; i++) begin
            apply_reset(tbl[i].est);
            botones = tbl[i].btn;
            #3;
            check($sformatf("tbl%0d_esperar", i), {9'b0, esperar}, {9'b0, tbl[i].exp_esp});
            @(posedge clk);
            #1;
            botones = '0;
            check($sformatf("tbl%0d_s", i), s, tbl[i].exp_s);
            check($sformatf("tbl%0d_puerta", i), {9'b0, puerta_abierta}, {9'b0, tbl[i].exp_p});
        end

        // Asynchronous reset while the door is open with every other request pending.
        apply_reset(4'b0100);
        botones = 10'h3FF;
        #3;
        check("fill_esperar", {9'b0, esperar}, 10'h001);
        @(posedge clk);
        #1;
        botones = '0;
        check("fill_s", s, 10'h3BE);
        check("fill_puerta", {9'b0, puerta_abierta}, 10'h001);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_s", s, 10'h000);
        check("async_rst_puerta", {9'b0, puerta_abierta}, 10'h000);
        check("async_rst_esperar", {9'b0, esperar}, 10'h000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Stop at floor2 heading up; cabin call for floor4 arrives mid-cycle.
        apply_reset(4'b1101);
        botones = 10'h086;
        @(posedge clk);
        #1;
        botones = '0;
        check("moving_latch_s", s, 10'h086);
        estado = 4'b0101;
        #3;
        check("stop_esperar", {9'b0, esperar}, 10'h001);
        check("stop_puerta", {9'b0, puerta_abierta}, 10'h000);
        @(posedge clk);
        #1;
        check("stop_clear_s", s, 10'h002);
        count_open(0, 3, n);
        check("stop_open_cycles", 10'(n), 10'd11);
        check("after_close_s", s, 10'h202);
        #3;
        check("after_close_esperar", {9'b0, esperar}, 10'h000);

        // Obstacle on the first closing cycle reopens the door.
        @(posedge clk);
        #1;
        botones = 10'h080;
        #3;
        check("cabin_open_esperar", {9'b0, esperar}, 10'h001);
        @(posedge clk);
        #1;
        botones = '0;
        check("cabin_open_s", s, 10'h202);
        check("cabin_open_puerta", {9'b0, puerta_abierta}, 10'h001);
        count_open(TA + 1, 0, n);
        check("obstacle_open_cycles", 10'(n), 10'd20);

        // Stop at the top floor clears bits 5 and 9 whatever the direction bit says.
        apply_reset(4'b1111);
        botones = 10'h330;
        @(posedge clk);
        #1;
        botones = '0;
        estado = 4'b0111;
        #3;
        check("top_stop_esperar", {9'b0, esperar}, 10'h001);
        @(posedge clk);
        #1;
        check("top_stop_s", s, 10'h110);

        // Randomized traffic against the reference model.
        apply_reset(4'b0100);
        m_s = '0;
        m_remain = 0;
        m_mov_prev = estado[3];
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                apply_reset({1'b0, estado[2:0]});
                m_s = '0;
                m_remain = 0;
                m_mov_prev = estado[3];
            end
            if (estado[3]) begin
                if ($urandom_range(3) == 0) estado[3] = 1'b0;
                else if ($urandom_range(3) == 0) estado[2:0] = 3'($urandom);
            end else if (m_remain == 0) begin
                if ($urandom_range(7) == 0) estado = {1'b1, 3'($urandom)};
                else if ($urandom_range(15) == 0) estado[2:0] = 3'($urandom);
            end
            botones = 10'($urandom & $urandom & $urandom & $urandom);
            obstaculo = ($urandom_range(7) == 0);

            mov = estado[3];
            up = estado[2];
            f = int'(estado[1:0]);
            mask = m_served(f, up);
            opp = m_opp(f, up);
            par = m_mov_prev && !mov;
            llam = !mov && ((((botones | m_s) & mask) != '0) || ((botones & opp) != '0));
            open = (m_remain > 0);
            esp = open || par || llam;
            #3;
            check("rnd_s", s, m_s);
            check("rnd_puerta", {9'b0, puerta_abierta}, {9'b0, open});
            check("rnd_esperar", {9'b0, esperar}, {9'b0, esp});
            @(posedge clk);
            clr_on = par || (!mov && (open || llam));
            trig = open ? (obstaculo || llam) : (par || llam);
            m_s = (m_s | botones) & (clr_on ? ~mask : 10'h3FF);
            m_remain = trig ? TA + TC : (open ? m_remain - 1 : 0);
            m_mov_prev = mov;
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
